// File: rtl/counter_32.sv
// Free-running up-counter with synchronous active-low reset; the count register
// drives the output directly, so out is glitch-free and never X at time zero.
module counter_32 #(
   parameter int unsigned      WIDTH      = 32,
   parameter logic [WIDTH-1:0] INIT_VALUE = '0,
   parameter logic [WIDTH-1:0] STEP       = 1
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] out
);

   // Declaration initialiser gives the power-up value before any edge or reset.
   logic [WIDTH-1:0] count_q = INIT_VALUE;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q + STEP;
   end

   // Reset wins over the pending increment; addition wraps modulo 2^WIDTH.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= INIT_VALUE;
      end else begin
         count_q <= count_d;
      end
   end

   assign out = count_q;

endmodule

// File: tb/tb_counter_32.sv
// Directed and randomized checks of counter_32 against an edge-counting model.
module tb_counter_32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rst_w = 1'b1;
   logic [31:0] out_m;
   logic [31:0] out_w;

   localparam logic [31:0] INIT_W = 32'hFFFF_FFFE;

   int unsigned    n_chk  = 0;
   int unsigned    n_fail = 0;
   longint unsigned n_m   = 0;
   longint unsigned n_w   = 0;

   counter_32 #(.WIDTH(32), .INIT_VALUE(32'd0), .STEP(32'd1)) u_main (
      .clk(clk), .rst(rst),   .out(out_m));

   counter_32 #(.WIDTH(32), .INIT_VALUE(INIT_W), .STEP(32'd1)) u_wrap (
      .clk(clk), .rst(rst_w), .out(out_w));

   always #5 clk = ~clk;

   // Expected count = init + (edges since last reset) * step, modulo 2^32.
   function automatic logic [31:0] model(input logic [31:0] init,
                                         input logic [31:0] step,
                                         input longint unsigned k);
      logic [63:0] full;
      full = 64'(init) + 64'(k) * 64'(step);
      return full[31:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (!rst)   n_m = 0; else n_m++;
      if (!rst_w) n_w = 0; else n_w++;
   endtask

   logic [31:0] held;

   initial begin
      // Power-up, clock idle-ish (first rising edge at 5 ns)
      #1;
      check("powerup_main", out_m, 32'd0);
      check("powerup_wrap", out_w, INIT_W);

      // Five edges: 1..5 on the main counter, wrap instance crosses 2^32
      for (int i = 1; i <= 5; i++) begin
         tick();
         check("count_main", out_m, model(32'd0, 32'd1, n_m));
         check("count_wrap", out_w, model(INIT_W, 32'd1, n_w));
      end
      check("wrap_abs", out_w, 32'd3);

      // Count up to 50
      while (n_m < 50) tick();
      check("count50", out_m, 32'd50);

      // rst pulse while clk steady low: no effect
      held = out_m;
      @(negedge clk);
      #1 rst = 1'b0;
      #3 rst = 1'b1;
      check("glitch_rst", out_m, held);

      // Hold reset for two edges, then release
      rst = 1'b0;
      tick();
      check("rst_edge1", out_m, 32'd0);
      tick();
      check("rst_edge2", out_m, 32'd0);
      rst = 1'b1;
      tick();
      check("release", out_m, 32'd1);

      // 50 rising edges; falling edges leave out unchanged
      rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         held = out_m;
         @(negedge clk);
         #1;
         check("negedge_hold", out_m, held);
      end
      check("count50b", out_m, model(32'd0, 32'd1, n_m));
      check("count50b_abs", out_m, 32'd50);

      // Reset asserted just before an edge that would otherwise increment
      @(negedge clk);
      #4 rst = 1'b0;
      tick();
      check("rst_priority", out_m, 32'd0);
      rst = 1'b1;

      // Reload wrap instance and walk across the boundary again
      rst_w = 1'b0;
      tick();
      check("wrap_reload", out_w, 32'hFFFF_FFFE);
      rst_w = 1'b1;
      tick();
      check("wrap_ffff", out_w, 32'hFFFF_FFFF);
      tick();
      check("wrap_zero", out_w, 32'h0000_0000);
      tick();
      check("wrap_one", out_w, 32'h0000_0001);

      // Randomized reset activity on both instances
      for (int i = 0; i < 300; i++) begin
         rst   = ($urandom_range(0, 7) != 0);
         rst_w = ($urandom_range(0, 5) != 0);
         tick();
         check("rand_main", out_m, model(32'd0, 32'd1, n_m));
         check("rand_wrap", out_w, model(INIT_W, 32'd1, n_w));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
